// File: rtl/voice_tuning_scheduler.sv
// Voice allocator and shared tuning-ROM sequencer for NUM_VOICES oscillator voices.
// Optional voice stealing when all voices sound: define VOICE_STEAL_EN.
module voice_tuning_scheduler #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned VW         = $clog2(NUM_VOICES)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_ev_valid,
  output logic                    o_ev_ready,
  input  logic                    i_ev_on,
  input  logic [6:0]              i_ev_note,
  output logic [6:0]              o_lut_note,
  input  logic [31:0]             i_lut_code,
  output logic [32*NUM_VOICES-1:0] o_tuning,
  output logic [7*NUM_VOICES-1:0]  o_note,
  output logic [NUM_VOICES-1:0]    o_gate,
  output logic                    o_drop
);

  typedef enum logic [1:0] {StIdle, StLookup, StWait} state_e;

  state_e                  state_q, state_d;
  logic [31:0]             tuning_q [NUM_VOICES];
  logic [31:0]             tuning_d [NUM_VOICES];
  logic [6:0]              note_q   [NUM_VOICES];
  logic [6:0]              note_d   [NUM_VOICES];
  logic [NUM_VOICES-1:0]   gate_q, gate_d;
  logic [VW-1:0]           target_q, target_d;
  logic [6:0]              lut_note_q, lut_note_d;
  logic                    drop_q, drop_d;

`ifdef VOICE_STEAL_EN
  logic [VW-1:0]           steal_ptr_q, steal_ptr_d;
`endif

  logic                    accept;
  logic                    hit_found, free_found, start;
  logic [VW-1:0]           hit_idx, free_idx, start_idx;

  assign accept = i_ev_valid && (state_q == StIdle);

  // Descending scan so the lowest matching index wins.
  always_comb begin
    hit_found  = 1'b0;
    free_found = 1'b0;
    hit_idx    = '0;
    free_idx   = '0;
    for (int i = int'(NUM_VOICES) - 1; i >= 0; i--) begin
      if (gate_q[i] && (note_q[i] == i_ev_note)) begin
        hit_found = 1'b1;
        hit_idx   = VW'(i);
      end
      if (!gate_q[i]) begin
        free_found = 1'b1;
        free_idx   = VW'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    tuning_d   = tuning_q;
    note_d     = note_q;
    gate_d     = gate_q;
    target_d   = target_q;
    lut_note_d = lut_note_q;
    drop_d     = 1'b0;
    start      = 1'b0;
    start_idx  = '0;
`ifdef VOICE_STEAL_EN
    steal_ptr_d = steal_ptr_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (!i_ev_on) begin
            for (int i = 0; i < int'(NUM_VOICES); i++) begin
              if (gate_q[i] && (note_q[i] == i_ev_note)) gate_d[i] = 1'b0;
            end
          end else if (hit_found) begin
            start     = 1'b1;
            start_idx = hit_idx;
          end else if (free_found) begin
            start     = 1'b1;
            start_idx = free_idx;
          end else begin
`ifdef VOICE_STEAL_EN
            start       = 1'b1;
            start_idx   = steal_ptr_q;
            steal_ptr_d = (steal_ptr_q == VW'(NUM_VOICES - 1)) ? '0 : steal_ptr_q + 1'b1;
`else
            drop_d = 1'b1;
`endif
          end
        end
        if (start) begin
          target_d           = start_idx;
          note_d[start_idx]  = i_ev_note;
          lut_note_d         = i_ev_note;
          state_d            = StLookup;
        end
      end
      StLookup: state_d = StWait;
      StWait: begin
        tuning_d[target_q] = i_lut_code;
        gate_d[target_q]   = 1'b1;
        state_d            = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      gate_q     <= '0;
      target_q   <= '0;
      lut_note_q <= '0;
      drop_q     <= 1'b0;
      for (int i = 0; i < int'(NUM_VOICES); i++) begin
        tuning_q[i] <= '0;
        note_q[i]   <= '0;
      end
`ifdef VOICE_STEAL_EN
      steal_ptr_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      gate_q     <= gate_d;
      target_q   <= target_d;
      lut_note_q <= lut_note_d;
      drop_q     <= drop_d;
      for (int i = 0; i < int'(NUM_VOICES); i++) begin
        tuning_q[i] <= tuning_d[i];
        note_q[i]   <= note_d[i];
      end
`ifdef VOICE_STEAL_EN
      steal_ptr_q <= steal_ptr_d;
`endif
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_out
    assign o_tuning[32*v +: 32] = tuning_q[v];
    assign o_note[7*v +: 7]     = note_q[v];
  end

  assign o_gate     = gate_q;
  assign o_lut_note = lut_note_q;
  assign o_drop     = drop_q;
  assign o_ev_ready = (state_q == StIdle);

endmodule

// File: tb/tb_voice_tuning_scheduler.sv
// Directed bench for voice_tuning_scheduler with a registered tuning-ROM model.
module tb_voice_tuning_scheduler;

  localparam int unsigned NV = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ev_valid = 1'b0;
  logic          ev_ready;
  logic          ev_on = 1'b0;
  logic [6:0]    ev_note = '0;
  logic [6:0]    lut_note;
  logic [31:0]   lut_code = '0;
  logic [32*NV-1:0] tuning;
  logic [7*NV-1:0]  note;
  logic [NV-1:0] gate;
  logic          drop;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  voice_tuning_scheduler #(.NUM_VOICES(NV), .VW(2)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_ev_valid (ev_valid),
    .o_ev_ready (ev_ready),
    .i_ev_on    (ev_on),
    .i_ev_note  (ev_note),
    .o_lut_note (lut_note),
    .i_lut_code (lut_code),
    .o_tuning   (tuning),
    .o_note     (note),
    .o_gate     (gate),
    .o_drop     (drop)
  );

  // Phase increments for a 48 MHz sample clock; other notes get a filler value.
  function automatic logic [31:0] rom(input logic [6:0] n);
    case (n)
      7'd60:   rom = 32'd23410;
      7'd62:   rom = 32'd26277;
      7'd64:   rom = 32'd29495;
      7'd65:   rom = 32'd31248;
      7'd69:   rom = 32'd39371;
      7'd72:   rom = 32'd46820;
      default: rom = 32'd1000 * {25'd0, n} + 32'd7;
    endcase
  endfunction

  always @(posedge clk) lut_code <= rom(lut_note);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    ev_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Presents one event for a single edge; call only when the DUT is idle.
  task automatic send(input logic on, input logic [6:0] n);
    ev_valid = 1'b1;
    ev_on    = on;
    ev_note  = n;
    @(posedge clk);
    #1 ev_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_ready", {31'd0, ev_ready}, 32'd1);
    chk("rst_gate", {28'd0, gate}, 32'd0);
    chk("rst_tuning0", tuning[31:0], 32'd0);
    chk("rst_note0", {25'd0, note[6:0]}, 32'd0);
    chk("rst_lut", {25'd0, lut_note}, 32'd0);
    chk("rst_drop", {31'd0, drop}, 32'd0);
    apply_reset();

    // 1: single note-on, latency and ready window
    send(1'b1, 7'd69);
    chk("t1_lookup_ready", {31'd0, ev_ready}, 32'd0);
    chk("t1_lut_note", {25'd0, lut_note}, 32'd69);
    chk("t1_note0", {25'd0, note[6:0]}, 32'd69);
    chk("t1_gate_lookup", {28'd0, gate}, 32'd0);
    step();
    chk("t1_wait_ready", {31'd0, ev_ready}, 32'd0);
    chk("t1_gate_wait", {28'd0, gate}, 32'd0);
    step();
    chk("t1_ready_back", {31'd0, ev_ready}, 32'd1);
    chk("t1_tuning0", tuning[31:0], 32'd39371);
    chk("t1_gate", {28'd0, gate}, 32'd1);

    // 2: allocate three voices, release one, refill it
    apply_reset();
    send(1'b1, 7'd60); repeat (2) step();
    send(1'b1, 7'd62); repeat (2) step();
    send(1'b1, 7'd64); repeat (2) step();
    chk("t2_gate_0111", {28'd0, gate}, 32'h7);
    chk("t2_tuning2", tuning[95:64], 32'd29495);
    send(1'b0, 7'd62);
    chk("t2_gate_0101", {28'd0, gate}, 32'h5);
    chk("t2_tuning1_kept", tuning[63:32], 32'd26277);
    chk("t2_note1_kept", {25'd0, note[13:7]}, 32'd62);
    chk("t2_off_ready", {31'd0, ev_ready}, 32'd1);
    send(1'b1, 7'd65); repeat (2) step();
    chk("t2_tuning1_new", tuning[63:32], 32'd31248);
    chk("t2_gate_refill", {28'd0, gate}, 32'h7);

    // 3: retrigger of a sounding note reuses its voice
    send(1'b1, 7'd60);
    chk("t3_gate_lookup", {28'd0, gate}, 32'h7);
    repeat (2) step();
    chk("t3_gate", {28'd0, gate}, 32'h7);
    chk("t3_note3", {25'd0, note[27:21]}, 32'd0);
    chk("t3_tuning0", tuning[31:0], 32'd23410);

    // 4: fill all voices, then one more note-on
    send(1'b1, 7'd72); repeat (2) step();
    chk("t4_gate_full", {28'd0, gate}, 32'hf);
    chk("t4_tuning3", tuning[127:96], 32'd46820);
    send(1'b1, 7'd74);
`ifdef VOICE_STEAL_EN
    chk("t4_steal_drop", {31'd0, drop}, 32'd0);
    chk("t4_steal_note0", {25'd0, note[6:0]}, 32'd74);
    repeat (2) step();
    chk("t4_steal_tuning0", tuning[31:0], rom(7'd74));
    chk("t4_steal_gate", {28'd0, gate}, 32'hf);
    send(1'b1, 7'd76); repeat (2) step();
    chk("t4_steal_tuning1", tuning[63:32], rom(7'd76));
    chk("t4_steal_tuning0_kept", tuning[31:0], rom(7'd74));
`else
    chk("t4_drop", {31'd0, drop}, 32'd1);
    chk("t4_drop_ready", {31'd0, ev_ready}, 32'd1);
    chk("t4_drop_lut", {25'd0, lut_note}, 32'd72);
    chk("t4_drop_tuning0", tuning[31:0], 32'd23410);
    chk("t4_drop_note0", {25'd0, note[6:0]}, 32'd60);
    chk("t4_drop_gate", {28'd0, gate}, 32'hf);
    step();
    chk("t4_drop_pulse_end", {31'd0, drop}, 32'd0);
`endif

    // 5: valid held high while busy; second event waits for idle
    apply_reset();
    send(1'b1, 7'd72); repeat (2) step();
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd48;
    step();
    ev_on = 1'b0; ev_note = 7'd72;
    chk("t5_busy_ready", {31'd0, ev_ready}, 32'd0);
    step();
    chk("t5_gate_wait", {28'd0, gate}, 32'h1);
    step();
    chk("t5_gate_on", {28'd0, gate}, 32'h3);
    chk("t5_tuning1", tuning[63:32], rom(7'd48));
    step();
    ev_valid = 1'b0;
    chk("t5_gate_off", {28'd0, gate}, 32'h2);
    send(1'b0, 7'd100);
    chk("t5_noop_gate", {28'd0, gate}, 32'h2);
    chk("t5_noop_ready", {31'd0, ev_ready}, 32'd1);

    // 6: reset during WAIT aborts the write
    send(1'b1, 7'd80);
    step();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_gate", {28'd0, gate}, 32'd0);
    chk("t6_rst_tuning1", tuning[63:32], 32'd0);
    chk("t6_rst_lut", {25'd0, lut_note}, 32'd0);
    chk("t6_rst_ready", {31'd0, ev_ready}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) step();
    chk("t6_post_gate", {28'd0, gate}, 32'd0);
    chk("t6_post_tuning0", tuning[31:0], 32'd0);
    chk("t6_post_ready", {31'd0, ev_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
